tmr_voter_mon: RTL and testbench

TMR_VOTER_MON -- requirements
Module: tmr_voter_mon

---
 rtl/tmr_pkg.sv | 17 +
 rtl/tmr_chan_health.sv | 78 +++++++
 rtl/tmr_voter_mon.sv | 130 +++++++++++++
 tb/tb_tmr_voter_mon.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared health-state type and default sizing for the TMR voter/monitor.
package tmr_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTED = 2'd2
  } health_e;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_FAULT_THRESH = 4;
  localparam int DEF_CNT_W        = 16;

  // Wide enough for any legal threshold (1..255).
  localparam int RUN_W = 8;

endpackage

// File: rtl/tmr_chan_health.sv
// Per-channel health tracker: HEALTHY/SUSPECT/FAULTED state, consecutive
// mismatch run length and a saturating lifetime mismatch counter.
module tmr_chan_health
  import tmr_pkg::*;
#(
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic             mismatch_i,
  input  logic             clr_i,
  output logic             fault_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  health_e          state_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  // Run length including the current sample; pinned at all-ones so it cannot wrap.
  assign run_d = (run_q == '1) ? run_q : run_q + 1'b1;

  // clr_i outranks a coincident sample, so that sample is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HEALTHY;
      run_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (clr_i) begin
      state_q <= HEALTHY;
      run_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (sample_i) begin
      if (mismatch_i) begin
        run_q <= run_d;
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
        case (state_q)
          HEALTHY, SUSPECT: begin
            if (run_d >= THRESH) begin
              state_q <= FAULTED;
              fault_q <= 1'b1;
            end else begin
              state_q <= SUSPECT;
            end
          end
          default: begin
            state_q <= FAULTED;
            fault_q <= 1'b1;
          end
        endcase
      end else begin
        run_q <= '0;
        case (state_q)
          HEALTHY, SUSPECT: state_q <= HEALTHY;
          default: begin
            state_q <= FAULTED;
            fault_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign fault_o   = fault_q;
  assign mis_cnt_o = cnt_q;

endmodule

// File: rtl/tmr_voter_mon.sv
// Triple-modular-redundancy voter with per-channel health monitoring.
// Define TMR_MASK_EN to exclude faulted channels from the vote.
module tmr_voter_mon
  import tmr_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_faults,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [2:0]       err,
  output logic [2:0]       fault,
  output logic             conflict,
  output logic [CNT_W-1:0] mis_cnt_a,
  output logic [CNT_W-1:0] mis_cnt_b,
  output logic [CNT_W-1:0] mis_cnt_c
);

  logic [WIDTH-1:0] majority;
  logic [2:0]       mismatch;
  logic [WIDTH-1:0] vote_d;
  logic             conflict_d;

  logic [WIDTH-1:0] y_q;
  logic             outValid_q;
  logic [2:0]       err_q;
  logic             conflict_q;

  // Health is always judged against the plain 3-way majority, faulted or not.
  assign majority = (a & b) | (a & c) | (b & c);
  assign mismatch = {c != majority, b != majority, a != majority};

`ifdef TMR_MASK_EN
  always_comb begin
    vote_d     = y_q;
    conflict_d = 1'b0;
    case (fault)
      3'b000: vote_d = majority;
      3'b001: begin
        if (b == c) vote_d = b;
        else        conflict_d = 1'b1;
      end
      3'b010: begin
        if (a == c) vote_d = a;
        else        conflict_d = 1'b1;
      end
      3'b100: begin
        if (a == b) vote_d = a;
        else        conflict_d = 1'b1;
      end
      default: conflict_d = 1'b1;
    endcase
  end
`else
  assign vote_d     = majority;
  assign conflict_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q        <= '0;
      outValid_q <= 1'b0;
      err_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        y_q        <= vote_d;
        err_q      <= mismatch;
        conflict_q <= conflict_d;
      end else begin
        err_q      <= '0;
        conflict_q <= 1'b0;
      end
    end
  end

  tmr_chan_health #(
    .FAULT_THRESH(FAULT_THRESH),
    .CNT_W       (CNT_W)
  ) u_health_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (in_valid),
    .mismatch_i(mismatch[0]),
    .clr_i     (clr_faults),
    .fault_o   (fault[0]),
    .mis_cnt_o (mis_cnt_a)
  );

  tmr_chan_health #(
    .FAULT_THRESH(FAULT_THRESH),
    .CNT_W       (CNT_W)
  ) u_health_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (in_valid),
    .mismatch_i(mismatch[1]),
    .clr_i     (clr_faults),
    .fault_o   (fault[1]),
    .mis_cnt_o (mis_cnt_b)
  );

  tmr_chan_health #(
    .FAULT_THRESH(FAULT_THRESH),
    .CNT_W       (CNT_W)
  ) u_health_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (in_valid),
    .mismatch_i(mismatch[2]),
    .clr_i     (clr_faults),
    .fault_o   (fault[2]),
    .mis_cnt_o (mis_cnt_c)
  );

  assign y         = y_q;
  assign out_valid = outValid_q;
  assign err       = err_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_tmr_voter_mon.sv
// Bench for tmr_voter_mon: two instances (default sizing, and threshold 1 with
// 2-bit counters) checked every cycle against a behavioural model.
module tb_tmr_voter_mon;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       in_valid   = 1'b0;
  logic [7:0] a          = 8'h00;
  logic [7:0] b          = 8'h00;
  logic [7:0] c          = 8'h00;
  logic       clr_faults = 1'b0;

  logic [7:0]  y0, y1;
  logic        ov0, ov1;
  logic [2:0]  err0, err1, fault0, fault1;
  logic        conf0, conf1;
  logic [15:0] cntA0, cntB0, cntC0;
  logic [1:0]  cntA1, cntB1, cntC1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tmr_voter_mon #(.WIDTH(8), .FAULT_THRESH(4), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_faults(clr_faults), .y(y0), .out_valid(ov0), .err(err0),
    .fault(fault0), .conflict(conf0),
    .mis_cnt_a(cntA0), .mis_cnt_b(cntB0), .mis_cnt_c(cntC0)
  );

  tmr_voter_mon #(.WIDTH(8), .FAULT_THRESH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_faults(clr_faults), .y(y1), .out_valid(ov1), .err(err1),
    .fault(fault1), .conflict(conf1),
    .mis_cnt_a(cntA1), .mis_cnt_b(cntB1), .mis_cnt_c(cntC1)
  );

  // Behavioural model: per instance, per channel run length / fault / count.
  int       threshOf[2] = '{4, 1};
  int       cntMaxOf[2] = '{65535, 3};
  int       runLen[2][3];
  bit       faulted[2][3];
  int       misCnt[2][3];
  bit [7:0] expY[2];
  bit       expOv[2];
  bit [2:0] expErr[2];
  bit       expConf[2];

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      expY[m] = '0; expOv[m] = 1'b0; expErr[m] = '0; expConf[m] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        runLen[m][k] = 0; faulted[m][k] = 1'b0; misCnt[m][k] = 0;
      end
    end
  endtask

  task automatic modelStep();
    bit [7:0] w[3];
    bit [7:0] maj;
    int       ones, nf, nh;
    int       h[2];
    w[0] = a; w[1] = b; w[2] = c;
    for (int bi = 0; bi < 8; bi++) begin
      ones = int'(w[0][bi]) + int'(w[1][bi]) + int'(w[2][bi]);
      maj[bi] = (ones >= 2);
    end
    for (int m = 0; m < 2; m++) begin
      expOv[m] = in_valid; expErr[m] = '0; expConf[m] = 1'b0;
      if (in_valid) begin
        for (int k = 0; k < 3; k++) expErr[m][k] = (w[k] != maj);
`ifdef TMR_MASK_EN
        nf = 0; nh = 0; h[0] = 0; h[1] = 0;
        for (int k = 0; k < 3; k++) begin
          if (faulted[m][k]) nf++;
          else if (nh < 2) begin h[nh] = k; nh++; end
        end
        if (nf == 0) expY[m] = maj;
        else if (nf == 1) begin
          if (w[h[0]] == w[h[1]]) expY[m] = w[h[0]];
          else expConf[m] = 1'b1;
        end else expConf[m] = 1'b1;
`else
        expY[m] = maj;
`endif
      end
      if (clr_faults) begin
        for (int k = 0; k < 3; k++) begin
          runLen[m][k] = 0; faulted[m][k] = 1'b0; misCnt[m][k] = 0;
        end
      end else if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          if (w[k] != maj) begin
            runLen[m][k]++;
            if (misCnt[m][k] < cntMaxOf[m]) misCnt[m][k]++;
            if (runLen[m][k] >= threshOf[m]) faulted[m][k] = 1'b1;
          end else begin
            runLen[m][k] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("m0_y",     y0,     expY[0]);
    checkOutput("m0_valid", ov0,    expOv[0]);
    checkOutput("m0_err",   err0,   expErr[0]);
    checkOutput("m0_conf",  conf0,  expConf[0]);
    checkOutput("m0_fault", fault0, {faulted[0][2], faulted[0][1], faulted[0][0]});
    checkOutput("m0_cntA",  cntA0,  misCnt[0][0]);
    checkOutput("m0_cntB",  cntB0,  misCnt[0][1]);
    checkOutput("m0_cntC",  cntC0,  misCnt[0][2]);
    checkOutput("m1_y",     y1,     expY[1]);
    checkOutput("m1_valid", ov1,    expOv[1]);
    checkOutput("m1_err",   err1,   expErr[1]);
    checkOutput("m1_conf",  conf1,  expConf[1]);
    checkOutput("m1_fault", fault1, {faulted[1][2], faulted[1][1], faulted[1][0]});
    checkOutput("m1_cntA",  cntA1,  misCnt[1][0]);
    checkOutput("m1_cntB",  cntB1,  misCnt[1][1]);
    checkOutput("m1_cntC",  cntC1,  misCnt[1][2]);
  end

  task automatic applyStimulus(input logic v, input logic [7:0] va, input logic [7:0] vb,
                               input logic [7:0] vc, input logic clr);
    @(negedge clk);
    in_valid = v; a = va; b = vb; c = vc; clr_faults = clr;
  endtask

  task automatic sampleOut();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] litY;
  logic       litConf;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_y", y0, 8'h00);
    checkOutput("rst_fault", fault0, 3'b000);
    checkOutput("rst_valid", ov0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0); sampleOut();
    checkOutput("agree_y", y0, 8'hA5);
    checkOutput("agree_valid", ov0, 1'b1);
    checkOutput("agree_err", err0, 3'b000);

    applyStimulus(1'b0, 8'h12, 8'h34, 8'h56, 1'b0); sampleOut();
    checkOutput("idle_valid", ov0, 1'b0);
    checkOutput("idle_hold_y", y0, 8'hA5);

    applyStimulus(1'b1, 8'h00, 8'hFF, 8'h0F, 1'b0); sampleOut();
    checkOutput("split_y", y0, 8'h0F);
    checkOutput("split_err", err0, 3'b011);
    checkOutput("split_cntA", cntA0, 16'd1);
    checkOutput("split_cntB", cntB0, 16'd1);
    checkOutput("split_fault_t4", fault0, 3'b000);
    checkOutput("split_fault_t1", fault1, 3'b011);

    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1); sampleOut();
    checkOutput("clr_fault_t1", fault1, 3'b000);
    checkOutput("clr_cntA", cntA0, 16'd0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0); sampleOut();
    checkOutput("run3_match_fault", fault0, 3'b000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0);
    sampleOut();
    checkOutput("run3_fault", fault0, 3'b000);
    applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0); sampleOut();
    checkOutput("run4_fault", fault0, 3'b100);
    checkOutput("run4_cntC", cntC0, 16'd7);
    checkOutput("sat2_cntC", cntC1, 2'd3);

    applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0); sampleOut();
    checkOutput("sticky_fault", fault0, 3'b100);
    checkOutput("sticky_err", err0, 3'b000);
    applyStimulus(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0); sampleOut();
    checkOutput("faulted_err", err0, 3'b100);
    checkOutput("faulted_cntC", cntC0, 16'd8);

`ifdef TMR_MASK_EN
    litY = 8'h3C; litConf = 1'b1;
`else
    litY = 8'h33; litConf = 1'b0;
`endif
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 1'b0); sampleOut();
    checkOutput("mask_y", y0, litY);
    checkOutput("mask_conf", conf0, litConf);
    checkOutput("mask_err", err0, 3'b011);

    applyStimulus(1'b1, 8'h00, 8'h00, 8'hFF, 1'b1); sampleOut();
    checkOutput("clrhit_fault", fault0, 3'b000);
    checkOutput("clrhit_cntC", cntC0, 16'd0);
    checkOutput("clrhit_y", y0, 8'h00);
    checkOutput("clrhit_err", err0, 3'b100);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
    sampleOut();
    checkOutput("sat_cntA_w2", cntA1, 2'd3);
    checkOutput("sat_cntA_w16", cntA0, 16'd5);
    checkOutput("sat_fault_t4", fault0, 3'b001);

    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h5A, 8'h5A, 8'hDA, 1'b0);
    applyStimulus(1'b1, 8'h5A, 8'h5A, 8'hDA, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_y", y0, 8'h00);
    checkOutput("midrst_cntC", cntC0, 16'd0);
    checkOutput("midrst_err", err0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h5A, 8'h5A, 8'hDA, 1'b0);
    sampleOut();
    checkOutput("fresh3_fault", fault0, 3'b000);
    applyStimulus(1'b1, 8'h5A, 8'h5A, 8'hDA, 1'b0); sampleOut();
    checkOutput("fresh4_fault", fault0, 3'b100);
    checkOutput("fresh4_cntC", cntC0, 16'd4);

    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
